// File: rtl/cache_block_transfer_unit.sv
// Memory-side block transfer engine: one-block write and read FIFOs sequenced onto a per-word bus.
// Define CACHE_XFER_STATS_EN to build the block-completion counters behind stat_rd_o / stat_wr_o.
module cache_block_transfer_unit #(
    parameter int BW_BLOCK        = 2,
    parameter int BW_ADDR         = 26,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               cmd_req_i,
    input  logic               cmd_block_i,
    input  logic               cmd_rw_i,
    input  logic [BW_ADDR-1:0] cmd_addr_i,
    output logic               cmd_ready_o,
    output logic               wbuf_ready_o,
    input  logic               wbuf_ack_i,
    input  logic [31:0]        wbuf_data_i,
    output logic               rbuf_ready_o,
    input  logic               rbuf_ack_i,
    output logic [31:0]        rbuf_data_o,
    output logic               ext_req_o,
    output logic               ext_rw_o,
    output logic [BW_ADDR-1:0] ext_addr_o,
    output logic [31:0]        ext_data_o,
    input  logic               ext_gnt_i,
    input  logic               ext_rvalid_i,
    input  logic [31:0]        ext_rdata_i,
    output logic [31:0]        stat_rd_o,
    output logic [31:0]        stat_wr_o
);
    localparam int DEPTH  = 1 << BW_BLOCK;
    localparam int BW_CNT = BW_BLOCK + 1;
    localparam int BW_OUT = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [BW_ADDR-1:0]  addr_r, addr_s;
    logic [BW_CNT-1:0]   remain_r, remain_s;
    logic                rw_r, rw_s, block_r, block_s;
    logic [BW_OUT-1:0]   outst_r, outst_s;
    logic                req_r, req_s, ready_r;
    logic [31:0]         wmem_r [DEPTH];
    logic [31:0]         rmem_r [DEPTH];
    logic [BW_BLOCK-1:0] wwr_r, wrd_r, rwr_r, rrd_r;
    logic [BW_CNT-1:0]   wcnt_r, wcnt_s, rcnt_r, rcnt_s;
    logic                wpush_s, wpop_s, rpush_s, rpop_s, grant_s, rx_s;

    // FIFO handshakes and next counts; returns only count while words are owed
    always_comb begin
        grant_s = req_r && ext_gnt_i;
        wpush_s = wbuf_ack_i && (wcnt_r < BW_CNT'(DEPTH));
        wpop_s  = grant_s && (state_r == WR_ISSUE);
        rx_s    = ext_rvalid_i && (outst_r != {BW_OUT{1'b0}});
        rpush_s = rx_s && (rcnt_r < BW_CNT'(DEPTH));
        rpop_s  = rbuf_ack_i && (rcnt_r != {BW_CNT{1'b0}});
        wcnt_s  = wcnt_r + BW_CNT'(wpush_s) - BW_CNT'(wpop_s);
        rcnt_s  = rcnt_r + BW_CNT'(rpush_s) - BW_CNT'(rpop_s);
        outst_s = outst_r + BW_OUT'(grant_s && (state_r == RD_ISSUE)) - BW_OUT'(rx_s);
    end

    // Next-state logic and next value of the registered bus request
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        remain_s = remain_r;
        rw_s     = rw_r;
        block_s  = block_r;
        case (state_r)
            IDLE: begin
                if (cmd_req_i && ready_r) begin
                    rw_s     = cmd_rw_i;
                    block_s  = cmd_block_i;
                    addr_s   = cmd_addr_i;
                    remain_s = cmd_block_i ? BW_CNT'(DEPTH) : BW_CNT'(1);
                    state_s  = cmd_rw_i ? WR_ISSUE : RD_ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ISSUE, WR_ISSUE: begin
                if (grant_s) begin
                    addr_s   = addr_r + BW_ADDR'(1);
                    remain_s = remain_r - BW_CNT'(1);
                    if (remain_r == BW_CNT'(1)) begin
                        state_s = (state_r == RD_ISSUE) ? RD_WAIT : IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            RD_WAIT: begin
                if (outst_s == {BW_OUT{1'b0}}) begin
                    state_s = IDLE;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            default: state_s = IDLE;
        endcase

        // Read credit counts both buffered words and words still in flight
        if (state_s == RD_ISSUE) begin
            req_s = ((32'(rcnt_s) + 32'(outst_s)) < 32'(DEPTH)) && (32'(outst_s) < 32'(MAX_OUTSTANDING));
        end else if (state_s == WR_ISSUE) begin
            req_s = (wcnt_s != {BW_CNT{1'b0}});
        end else begin
            req_s = 1'b0;
        end
    end

    // Control state, counts and pointers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            addr_r   <= {BW_ADDR{1'b0}};
            remain_r <= {BW_CNT{1'b0}};
            rw_r     <= 1'b0;
            block_r  <= 1'b0;
            outst_r  <= {BW_OUT{1'b0}};
            req_r    <= 1'b0;
            ready_r  <= 1'b1;
            wcnt_r   <= {BW_CNT{1'b0}};
            rcnt_r   <= {BW_CNT{1'b0}};
            wwr_r    <= {BW_BLOCK{1'b0}};
            wrd_r    <= {BW_BLOCK{1'b0}};
            rwr_r    <= {BW_BLOCK{1'b0}};
            rrd_r    <= {BW_BLOCK{1'b0}};
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            remain_r <= remain_s;
            rw_r     <= rw_s;
            block_r  <= block_s;
            outst_r  <= outst_s;
            req_r    <= req_s;
            ready_r  <= (state_s == IDLE);
            wcnt_r   <= wcnt_s;
            rcnt_r   <= rcnt_s;
            if (wpush_s) wwr_r <= wwr_r + BW_BLOCK'(1);
            if (wpop_s)  wrd_r <= wrd_r + BW_BLOCK'(1);
            if (rpush_s) rwr_r <= rwr_r + BW_BLOCK'(1);
            if (rpop_s)  rrd_r <= rrd_r + BW_BLOCK'(1);
        end
    end

    // FIFO storage; contents are only visible through the counts
    always_ff @(posedge clock_i) begin
        if (wpush_s) wmem_r[wwr_r] <= wbuf_data_i;
        if (rpush_s) rmem_r[rwr_r] <= ext_rdata_i;
    end

    assign cmd_ready_o  = ready_r;
    assign wbuf_ready_o = (wcnt_r < BW_CNT'(DEPTH));
    assign rbuf_ready_o = (rcnt_r != {BW_CNT{1'b0}});
    assign rbuf_data_o  = rbuf_ready_o ? rmem_r[rrd_r] : 32'h0;
    assign ext_req_o    = req_r;
    assign ext_rw_o     = rw_r;
    assign ext_addr_o   = addr_r;
    assign ext_data_o   = (wcnt_r != {BW_CNT{1'b0}}) ? wmem_r[wrd_r] : 32'h0;

`ifdef CACHE_XFER_STATS_EN
    logic [31:0] stat_rd_r, stat_wr_r;
    logic        rd_done_s, wr_done_s;

    assign rd_done_s = block_r && (state_r == RD_WAIT) && (state_s == IDLE);
    assign wr_done_s = block_r && (state_r == WR_ISSUE) && (state_s == IDLE);

    // Block completion counters, wrapping naturally
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stat_rd_r <= 32'h0;
            stat_wr_r <= 32'h0;
        end else begin
            if (rd_done_s) stat_rd_r <= stat_rd_r + 32'd1;
            if (wr_done_s) stat_wr_r <= stat_wr_r + 32'd1;
        end
    end

    assign stat_rd_o = stat_rd_r;
    assign stat_wr_o = stat_wr_r;
`else
    logic unused_s;
    assign unused_s  = block_r;
    assign stat_rd_o = 32'h0;
    assign stat_wr_o = 32'h0;
`endif
endmodule

// File: tb/tb_cache_block_transfer_unit.sv
// Directed bench for cache_block_transfer_unit: a word-bus memory model answers reads two cycles after grant.
module tb_cache_block_transfer_unit;
    logic        clock, reset_i;
    logic        cmd_req_i, cmd_block_i, cmd_rw_i;
    logic [25:0] cmd_addr_i;
    logic        cmd_ready_o, wbuf_ready_o, wbuf_ack_i, rbuf_ready_o, rbuf_ack_i;
    logic [31:0] wbuf_data_i, rbuf_data_o;
    logic        ext_req_o, ext_rw_o, ext_gnt_i, ext_rvalid_i;
    logic [25:0] ext_addr_o;
    logic [31:0] ext_data_o, ext_rdata_i, stat_rd_o, stat_wr_o;

    cache_block_transfer_unit #(.BW_BLOCK(2), .BW_ADDR(26), .MAX_OUTSTANDING(4)) dut (
        .clock_i(clock), .reset_i(reset_i),
        .cmd_req_i(cmd_req_i), .cmd_block_i(cmd_block_i), .cmd_rw_i(cmd_rw_i), .cmd_addr_i(cmd_addr_i),
        .cmd_ready_o(cmd_ready_o),
        .wbuf_ready_o(wbuf_ready_o), .wbuf_ack_i(wbuf_ack_i), .wbuf_data_i(wbuf_data_i),
        .rbuf_ready_o(rbuf_ready_o), .rbuf_ack_i(rbuf_ack_i), .rbuf_data_o(rbuf_data_o),
        .ext_req_o(ext_req_o), .ext_rw_o(ext_rw_o), .ext_addr_o(ext_addr_o), .ext_data_o(ext_data_o),
        .ext_gnt_i(ext_gnt_i), .ext_rvalid_i(ext_rvalid_i), .ext_rdata_i(ext_rdata_i),
        .stat_rd_o(stat_rd_o), .stat_wr_o(stat_wr_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int chk_cnt = 0;
    int pass_cnt = 0;
    bit gnt_en, pop_en, resp_en;
    bit          pipe_v [2];
    logic [31:0] pipe_d [2];
    logic [25:0] addr_q [$];
    bit          rw_q [$];
    logic [31:0] wdata_q [$];
    logic [31:0] pop_q [$];
    int          pops_at_grant [$];
    int          rv_cnt;

    // One clock; then memory model and cache-side popper react to the new outputs
    task automatic step();
        @(posedge clock);
        #1;
        cmd_req_i    = 1'b0;
        wbuf_ack_i   = 1'b0;
        ext_rvalid_i = pipe_v[0];
        ext_rdata_i  = pipe_d[0];
        if (pipe_v[0]) rv_cnt++;
        pipe_v[0] = pipe_v[1];
        pipe_d[0] = pipe_d[1];
        pipe_v[1] = 1'b0;
        pipe_d[1] = 32'h0;
        ext_gnt_i = gnt_en;
        if (gnt_en && ext_req_o) begin
            addr_q.push_back(ext_addr_o);
            rw_q.push_back(ext_rw_o);
            wdata_q.push_back(ext_data_o);
            pops_at_grant.push_back(pop_q.size());
            if (!ext_rw_o && resp_en) begin
                pipe_v[1] = 1'b1;
                pipe_d[1] = 32'hA500_0000 | {6'h0, ext_addr_o};
            end
        end
        rbuf_ack_i = pop_en && rbuf_ready_o;
        if (rbuf_ack_i) pop_q.push_back(rbuf_data_o);
    endtask

    task automatic clear_logs();
        addr_q.delete(); rw_q.delete(); wdata_q.delete(); pop_q.delete(); pops_at_grant.delete();
        rv_cnt = 0;
        pipe_v[0] = 1'b0; pipe_v[1] = 1'b0; pipe_d[0] = 32'h0; pipe_d[1] = 32'h0;
    endtask

    task automatic issue_cmd(input bit rw, input bit block, input logic [25:0] addr);
        cmd_req_i = 1'b1; cmd_rw_i = rw; cmd_block_i = block; cmd_addr_i = addr;
        step();
    endtask

    task automatic push_word(input logic [31:0] d);
        wbuf_data_i = d; wbuf_ack_i = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (cmd_ready_o && !(pop_en && rbuf_ready_o)) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        step(); step();
        chk_cnt++; if (cmd_ready_o !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o); else pass_cnt++;
        chk_cnt++; if (ext_req_o !== 1'b0) $display("FAIL reset_ext_req: got %b want 0", ext_req_o); else pass_cnt++;
        chk_cnt++; if (ext_rw_o !== 1'b0) $display("FAIL reset_ext_rw: got %b want 0", ext_rw_o); else pass_cnt++;
        chk_cnt++; if (ext_addr_o !== 26'h0) $display("FAIL reset_ext_addr: got %h want 0", ext_addr_o); else pass_cnt++;
        chk_cnt++; if (ext_data_o !== 32'h0) $display("FAIL reset_ext_data: got %h want 0", ext_data_o); else pass_cnt++;
        chk_cnt++; if (rbuf_ready_o !== 1'b0) $display("FAIL reset_rbuf_ready: got %b want 0", rbuf_ready_o); else pass_cnt++;
        chk_cnt++; if (wbuf_ready_o !== 1'b1) $display("FAIL reset_wbuf_ready: got %b want 1", wbuf_ready_o); else pass_cnt++;
        chk_cnt++; if (stat_rd_o !== 32'h0) $display("FAIL reset_stat_rd: got %0d want 0", stat_rd_o); else pass_cnt++;
        chk_cnt++; if (stat_wr_o !== 32'h0) $display("FAIL reset_stat_wr: got %0d want 0", stat_wr_o); else pass_cnt++;
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_block_read();
        logic [25:0] ea;
        clear_logs();
        gnt_en = 1'b1; pop_en = 1'b1; resp_en = 1'b1;
        issue_cmd(1'b0, 1'b1, 26'h100);
        for (int i = 0; i < 40 && rv_cnt < 4; i++) step();
        chk_cnt++; if (rv_cnt !== 4) $display("FAIL rd_rvalid_count: got %0d want 4", rv_cnt); else pass_cnt++;
        chk_cnt++; if (cmd_ready_o !== 1'b0) $display("FAIL rd_ready_at_last_rvalid: got %b want 0", cmd_ready_o); else pass_cnt++;
        step();
        chk_cnt++; if (cmd_ready_o !== 1'b1) $display("FAIL rd_ready_after_last_rvalid: got %b want 1", cmd_ready_o); else pass_cnt++;
        repeat (3) step();
        chk_cnt++; if (addr_q.size() !== 4) $display("FAIL rd_grant_count: got %0d want 4", addr_q.size()); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            ea = 26'h100 + 26'(i);
            chk_cnt++; if (addr_q[i] !== ea || rw_q[i] !== 1'b0) $display("FAIL rd_addr%0d: got %h rw %b want %h rw 0", i, addr_q[i], rw_q[i], ea); else pass_cnt++;
            chk_cnt++; if (pop_q[i] !== (32'hA500_0100 + 32'(i))) $display("FAIL rd_data%0d: got %h want %h", i, pop_q[i], 32'hA500_0100 + 32'(i)); else pass_cnt++;
        end
        chk_cnt++; if (pop_q.size() !== 4) $display("FAIL rd_pop_count: got %0d want 4", pop_q.size()); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        gnt_en = 1'b1; pop_en = 1'b0; resp_en = 1'b1;
        issue_cmd(1'b0, 1'b1, 26'h200);
        wait_idle(40, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL bp_first_done: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (rbuf_ready_o !== 1'b1) $display("FAIL bp_rbuf_full: got %b want 1", rbuf_ready_o); else pass_cnt++;
        issue_cmd(1'b0, 1'b1, 26'h204);
        repeat (8) step();
        chk_cnt++; if (addr_q.size() !== 4) $display("FAIL bp_no_issue_while_full: got %0d grants want 4", addr_q.size()); else pass_cnt++;
        chk_cnt++; if (ext_req_o !== 1'b0) $display("FAIL bp_req_held_low: got %b want 0", ext_req_o); else pass_cnt++;
        pop_en = 1'b1;
        wait_idle(80, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL bp_second_done: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (pop_q.size() !== 8) $display("FAIL bp_pop_count: got %0d want 8", pop_q.size()); else pass_cnt++;
        chk_cnt++; if ((pops_at_grant[4] > 0) !== 1'b1) $display("FAIL bp_issue_after_pop: got %0d pops want >0", pops_at_grant[4]); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            chk_cnt++; if (addr_q[i] !== (26'h200 + 26'(i)) || pop_q[i] !== (32'hA500_0200 + 32'(i)))
                $display("FAIL bp_word%0d: got addr %h data %h want addr %h data %h", i, addr_q[i], pop_q[i], 26'h200 + 26'(i), 32'hA500_0200 + 32'(i));
            else pass_cnt++;
        end
    endtask

    task automatic test_partial_write();
        bit ok, stall_seen;
        clear_logs();
        gnt_en = 1'b1; pop_en = 1'b0; resp_en = 1'b1; stall_seen = 1'b0;
        push_word(32'hC0DE_0000);
        issue_cmd(1'b1, 1'b1, 26'h2FC);
        for (int k = 1; k < 4; k++) begin
            repeat (2) begin
                step();
                if (!ext_req_o && !cmd_ready_o) stall_seen = 1'b1;
            end
            push_word(32'hC0DE_0000 + 32'(k));
        end
        wait_idle(30, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL wr_done: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (stall_seen !== 1'b1) $display("FAIL wr_stall_on_empty: got %b want 1", stall_seen); else pass_cnt++;
        chk_cnt++; if (addr_q.size() !== 4) $display("FAIL wr_grant_count: got %0d want 4", addr_q.size()); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (addr_q[i] !== (26'h2FC + 26'(i)) || rw_q[i] !== 1'b1 || wdata_q[i] !== (32'hC0DE_0000 + 32'(i)))
                $display("FAIL wr_word%0d: got addr %h rw %b data %h want addr %h rw 1 data %h", i, addr_q[i], rw_q[i], wdata_q[i], 26'h2FC + 26'(i), 32'hC0DE_0000 + 32'(i));
            else pass_cnt++;
        end
        chk_cnt++; if (wbuf_ready_o !== 1'b1 || ext_data_o !== 32'h0) $display("FAIL wr_fifo_empty: got ready %b data %h want 1 0", wbuf_ready_o, ext_data_o); else pass_cnt++;
    endtask

    task automatic test_addr_wrap();
        bit ok;
        logic [25:0] ea [5] = '{26'h3FF_FFFF, 26'h3FF_FFFF, 26'h000_0000, 26'h000_0001, 26'h000_0002};
        logic [31:0] ed [4] = '{32'hA7FF_FFFF, 32'hA500_0000, 32'hA500_0001, 32'hA500_0002};
        clear_logs();
        gnt_en = 1'b0; pop_en = 1'b1; resp_en = 1'b1;
        push_word(32'h1234_5678);
        issue_cmd(1'b1, 1'b0, 26'h3FF_FFFF);
        repeat (3) step();
        chk_cnt++; if (ext_req_o !== 1'b1 || ext_rw_o !== 1'b1 || ext_addr_o !== 26'h3FF_FFFF || ext_data_o !== 32'h1234_5678)
            $display("FAIL hold_while_no_gnt: got req %b rw %b addr %h data %h want 1 1 3ffffff 12345678", ext_req_o, ext_rw_o, ext_addr_o, ext_data_o);
        else pass_cnt++;
        gnt_en = 1'b1;
        wait_idle(20, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL wrap_write_done: got %b want 1", ok); else pass_cnt++;
        issue_cmd(1'b0, 1'b1, 26'h3FF_FFFF);
        wait_idle(40, ok);
        chk_cnt++; if (ok !== 1'b1) $display("FAIL wrap_read_done: got %b want 1", ok); else pass_cnt++;
        chk_cnt++; if (addr_q.size() !== 5 || pop_q.size() !== 4) $display("FAIL wrap_counts: got %0d grants %0d pops want 5 4", addr_q.size(), pop_q.size()); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (addr_q[i] !== ea[i] || rw_q[i] !== (i == 0)) $display("FAIL wrap_addr%0d: got %h rw %b want %h rw %b", i, addr_q[i], rw_q[i], ea[i], i == 0); else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (pop_q[i] !== ed[i]) $display("FAIL wrap_data%0d: got %h want %h", i, pop_q[i], ed[i]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        clear_logs();
        gnt_en = 1'b1; pop_en = 1'b0; resp_en = 1'b0;
        issue_cmd(1'b0, 1'b1, 26'h040);
        for (int i = 0; i < 10 && addr_q.size() < 2; i++) step();
        gnt_en = 1'b0;
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk_cnt++; if (cmd_ready_o !== 1'b1 || ext_req_o !== 1'b0) $display("FAIL rst_mid_idle: got ready %b req %b want 1 0", cmd_ready_o, ext_req_o); else pass_cnt++;
        ext_rvalid_i = 1'b1; ext_rdata_i = 32'hDEAD_0001;
        step();
        ext_rvalid_i = 1'b1; ext_rdata_i = 32'hDEAD_0002;
        step();
        step();
        chk_cnt++; if (rbuf_ready_o !== 1'b0) $display("FAIL rst_mid_stray_dropped: got %b want 0", rbuf_ready_o); else pass_cnt++;
        chk_cnt++; if (addr_q.size() !== 2) $display("FAIL rst_mid_grants: got %0d want 2", addr_q.size()); else pass_cnt++;
        clear_logs();
        gnt_en = 1'b1; pop_en = 1'b1; resp_en = 1'b1;
        issue_cmd(1'b0, 1'b1, 26'h050);
        wait_idle(40, ok);
        chk_cnt++; if (ok !== 1'b1 || pop_q.size() !== 4) $display("FAIL rst_mid_next_read: got done %b pops %0d want 1 4", ok, pop_q.size()); else pass_cnt++;
        chk_cnt++; if (pop_q[0] !== 32'hA500_0050) $display("FAIL rst_mid_next_data: got %h want a5000050", pop_q[0]); else pass_cnt++;
    endtask

    task automatic test_stats();
        bit ok;
        int fails;
        logic [31:0] exp_rd, exp_wr;
`ifdef CACHE_XFER_STATS_EN
        exp_rd = 32'd3; exp_wr = 32'd2;
`else
        exp_rd = 32'd0; exp_wr = 32'd0;
`endif
        reset_i = 1'b1; step(); reset_i = 1'b0; step();
        clear_logs();
        gnt_en = 1'b1; pop_en = 1'b1; resp_en = 1'b1; fails = 0;
        for (int i = 0; i < 3; i++) begin
            issue_cmd(1'b0, 1'b1, 26'h400 + 26'(4 * i));
            wait_idle(40, ok);
            if (!ok) fails++;
        end
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) push_word(32'h5000_0000 + 32'(4 * i + k));
            issue_cmd(1'b1, 1'b1, 26'h600 + 26'(4 * i));
            wait_idle(40, ok);
            if (!ok) fails++;
        end
        issue_cmd(1'b0, 1'b0, 26'h700);
        wait_idle(40, ok);
        if (!ok) fails++;
        chk_cnt++; if (fails !== 0) $display("FAIL stats_timeouts: got %0d want 0", fails); else pass_cnt++;
        chk_cnt++; if (addr_q.size() !== 21 || pop_q.size() !== 13) $display("FAIL stats_traffic: got %0d grants %0d pops want 21 13", addr_q.size(), pop_q.size()); else pass_cnt++;
        chk_cnt++; if (stat_rd_o !== exp_rd) $display("FAIL stats_rd: got %0d want %0d", stat_rd_o, exp_rd); else pass_cnt++;
        chk_cnt++; if (stat_wr_o !== exp_wr) $display("FAIL stats_wr: got %0d want %0d", stat_wr_o, exp_wr); else pass_cnt++;
    endtask

    initial begin
        reset_i = 1'b1; cmd_req_i = 1'b0; cmd_block_i = 1'b0; cmd_rw_i = 1'b0; cmd_addr_i = 26'h0;
        wbuf_ack_i = 1'b0; wbuf_data_i = 32'h0; rbuf_ack_i = 1'b0;
        ext_gnt_i = 1'b0; ext_rvalid_i = 1'b0; ext_rdata_i = 32'h0;
        gnt_en = 1'b0; pop_en = 1'b0; resp_en = 1'b0;
        clear_logs();
        test_reset();
        test_block_read();
        test_backpressure();
        test_partial_write();
        test_addr_wrap();
        test_reset_mid_read();
        test_stats();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", chk_cnt);
        $fatal(1);
    end
endmodule
